// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and helpers for the synchronous FIFO family.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Read-side presentation modes
    localparam int FIFO_STD  = 0;   // registered read, one cycle after rd
    localparam int FIFO_FWFT = 1;   // head word shown combinationally

    // Ceiling log2, returns at least 1 so address buses never collapse to zero width
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_dp.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem_dp
//  Description : DEPTH x DATA_WIDTH storage, one synchronous write port and one
//                asynchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port: store the word on an accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Single-clock parametrised FIFO with occupancy count,
//                almost-full/almost-empty flags, optional first-word-fall-through
//                read side and simultaneous read+write on a full FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0,
    localparam int ADDR_W    = clog2(DEPTH),
    localparam int CNT_W     = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_af    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] c_ae    = CNT_W'(AE_THRESH);

    // Reject configurations the pointer/counter scheme cannot represent
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_chk_af
        $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_chk_ae
        $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // Flags are pure decodes of the registered count
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // A read frees a slot in the same cycle, so a full FIFO can still take a write
    assign w_rd_ok = rd && !w_empty;
    assign w_wr_ok = wr && (!w_full || w_rd_ok);

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_ok && !rst),
        .waddr (r_wr_ptr),
        .wdata (wdata),
        .raddr (r_rd_ptr),
        .rdata (w_mem_rdata)
    );

    // Pointers, occupancy counter and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow  <= wr && !w_wr_ok;
            r_underflow <= rd && !w_rd_ok;
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word is always visible; rd acknowledges it
        assign rdata = w_mem_rdata;
        assign valid = !w_empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_rdata;
        logic                  r_valid;

        // Registered read: capture the head word on an accepted read
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rdata <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_ok;
                if (w_rd_ok) begin
                    r_rdata <= w_mem_rdata;
                end
            end
        end

        assign rdata = r_rdata;
        assign valid = r_valid;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_af);
    assign almost_empty = (r_count <= c_ae);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
